// File: rtl/uart_mem_pkg.sv
// Shared types for the UART-backed memory read-port arbiter.
package uart_mem_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Busy = 2'd1,
        Resp = 2'd2
    } arb_state_e;

    // Requester indices; also the bit positions in the rr_arb2 request vector.
    localparam logic ReqIf = 1'b0;
    localparam logic ReqD  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the side that did not win last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_valid_c,
    output logic       gnt_idx_c
);

    always_comb begin
        gnt_valid_c = |req_i;
        gnt_idx_c   = req_i[1];
        if (&req_i) begin
            gnt_idx_c = ~last_i;
        end
    end

endmodule

// File: rtl/uart_mem_arbiter.sv
// Shares the single uart_ram read port between instruction fetch and data load,
// one outstanding transaction at a time, with a watchdog and a protocol-error flag.
module uart_mem_arbiter
    import uart_mem_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 32'd2000000,
    parameter int unsigned CntWidth      = 22
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 if_valid_i,
    input  logic [AddrWidth-1:0] if_addr_i,
    output logic [DataWidth-1:0] if_data_o,
    output logic                 if_ready_o,
    input  logic                 d_valid_i,
    input  logic [AddrWidth-1:0] d_addr_i,
    output logic [DataWidth-1:0] d_data_o,
    output logic                 d_ready_o,
    output logic                 mem_rd_valid_o,
    output logic [AddrWidth-1:0] mem_rd_addr_o,
    input  logic [DataWidth-1:0] mem_rd_data_i,
    input  logic                 mem_rd_ready_i,
    output logic                 timeout_o,
    output logic                 proto_err_o
);

    localparam logic [CntWidth-1:0] WdogMax = CntWidth'(TimeoutCycles);

    arb_state_e           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q, last_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [CntWidth-1:0]  wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;
    logic                 proto_err_q, proto_err_d;
    logic                 mem_rd_valid_q, mem_rd_valid_d;
    logic                 if_ready_q, if_ready_d;
    logic                 d_ready_q, d_ready_d;

    logic gnt_valid_c;
    logic gnt_idx_c;

    rr_arb2 u_rr_arb2 (
        .req_i       ({d_valid_i, if_valid_i}),
        .last_i      (last_q),
        .gnt_valid_c (gnt_valid_c),
        .gnt_idx_c   (gnt_idx_c)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wdog_d      = wdog_q;
        timeout_d   = timeout_q;
        proto_err_d = proto_err_q;

        unique case (state_q)
            Idle: begin
                if (gnt_valid_c) begin
                    owner_d = gnt_idx_c;
                    last_d  = gnt_idx_c;
                    addr_d  = (gnt_idx_c == ReqD) ? d_addr_i : if_addr_i;
                    wdog_d  = '0;
                    state_d = Busy;
                end
            end
            Busy: begin
                if (mem_rd_ready_i) begin
                    data_d  = mem_rd_data_i;
                    state_d = Resp;
                end else if (wdog_q != WdogMax) begin
                    wdog_d = wdog_q + CntWidth'(1);
                end
                // uart_ram cannot be aborted, so an expired watchdog only raises the flag.
                if (wdog_d == WdogMax) begin
                    timeout_d = 1'b1;
                end
            end
            Resp: begin
                state_d = Idle;
            end
            default: begin
                state_d = Idle;
            end
        endcase

        if (mem_rd_ready_i && (state_q != Busy)) begin
            proto_err_d = 1'b1;
        end

        mem_rd_valid_d = (state_d == Busy);
        if_ready_d     = (state_d == Resp) && (owner_d == ReqIf);
        d_ready_d      = (state_d == Resp) && (owner_d == ReqD);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= Idle;
            owner_q        <= ReqIf;
            last_q         <= ReqIf;
            addr_q         <= '0;
            data_q         <= '0;
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
            proto_err_q    <= 1'b0;
            mem_rd_valid_q <= 1'b0;
            if_ready_q     <= 1'b0;
            d_ready_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            wdog_q         <= wdog_d;
            timeout_q      <= timeout_d;
            proto_err_q    <= proto_err_d;
            mem_rd_valid_q <= mem_rd_valid_d;
            if_ready_q     <= if_ready_d;
            d_ready_q      <= d_ready_d;
        end
    end

    assign if_data_o      = data_q;
    assign d_data_o       = data_q;
    assign if_ready_o     = if_ready_q;
    assign d_ready_o      = d_ready_q;
    assign mem_rd_valid_o = mem_rd_valid_q;
    assign mem_rd_addr_o  = addr_q;
    assign timeout_o      = timeout_q;
    assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed and randomized bench for uart_mem_arbiter with a transaction-level reference model.
module tb_uart_mem_arbiter;

    localparam int unsigned TC = 100;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        if_valid_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        d_valid_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_o;
    logic        d_ready_o;
    logic        mem_rd_valid_o;
    logic [31:0] mem_rd_addr_o;
    logic [31:0] mem_rd_data_i;
    logic        mem_rd_ready_i;
    logic        timeout_o;
    logic        proto_err_o;

    int checks = 0;
    int errors = 0;

    uart_mem_arbiter #(
        .TimeoutCycles (TC),
        .CntWidth      (22)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .if_valid_i     (if_valid_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_ready_o     (if_ready_o),
        .d_valid_i      (d_valid_i),
        .d_addr_i       (d_addr_i),
        .d_data_o       (d_data_o),
        .d_ready_o      (d_ready_o),
        .mem_rd_valid_o (mem_rd_valid_o),
        .mem_rd_addr_o  (mem_rd_addr_o),
        .mem_rd_data_i  (mem_rd_data_i),
        .mem_rd_ready_i (mem_rd_ready_i),
        .timeout_o      (timeout_o),
        .proto_err_o    (proto_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        if_valid_i     = 1'b0;
        d_valid_i      = 1'b0;
        if_addr_i      = $urandom;
        d_addr_i       = $urandom;
        mem_rd_ready_i = 1'b0;
        mem_rd_data_i  = $urandom;
    endtask

    task automatic do_reset();
        drive_idle();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
    endtask

    // Steps until the read port shows valid; returns the number of clocks taken (400 = gave up).
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (mem_rd_valid_o !== 1'b1 && n < 400);
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_rdvalid"}, mem_rd_valid_o, 1'b0);
        chk({tag, "_rdaddr"}, mem_rd_addr_o, 32'h0);
        chk1({tag, "_ifrdy"}, if_ready_o, 1'b0);
        chk1({tag, "_drdy"}, d_ready_o, 1'b0);
        chk({tag, "_ifdata"}, if_data_o, 32'h0);
        chk({tag, "_ddata"}, d_data_o, 32'h0);
        chk1({tag, "_timeout"}, timeout_o, 1'b0);
        chk1({tag, "_proto"}, proto_err_o, 1'b0);
    endtask

    // Plays uart_ram for one transaction already showing valid: lat cycles of wait, then ready+data.
    task automatic serve(input string tag, input logic owner, input logic [31:0] addr,
                         input int lat, input logic [31:0] data);
        bit held;
        held = 1'b1;
        chk({tag, "_addr"}, mem_rd_addr_o, addr);
        repeat (lat) begin
            step();
            mem_rd_data_i = $urandom;
            held = held & (mem_rd_valid_o === 1'b1) & (mem_rd_addr_o === addr);
        end
        chk1({tag, "_held"}, held, 1'b1);
        mem_rd_ready_i = 1'b1;
        mem_rd_data_i  = data;
        step();
        mem_rd_ready_i = 1'b0;
        mem_rd_data_i  = $urandom;
        chk1({tag, "_ifrdy"}, if_ready_o, owner == 1'b0);
        chk1({tag, "_drdy"}, d_ready_o, owner == 1'b1);
        chk({tag, "_data"}, owner ? d_data_o : if_data_o, data);
        chk1({tag, "_rdvalid_off"}, mem_rd_valid_o, 1'b0);
    endtask

    initial begin
        int          n;
        int          lat;
        int          exp_n;
        logic [1:0]  pend;
        logic [31:0] addr_m [2];
        logic [31:0] dat;
        logic        last_m;
        logic        w;
        bit          after_resp;

        reset_i = 1'b0;
        do_reset();
        chk_all_zero("reset");

        // Single fetch with a slow memory.
        if_addr_i  = 32'h0000_0010;
        if_valid_i = 1'b1;
        wait_valid(n);
        chk("t1_lat", 32'(n), 32'd1);
        serve("t1", 1'b0, 32'h10, 50, 32'hDEAD_BEEF);
        if_valid_i = 1'b0;

        // First tie after reset goes to data; loser follows after exactly two low cycles.
        do_reset();
        if_addr_i  = 32'h100;
        d_addr_i   = 32'h200;
        if_valid_i = 1'b1;
        d_valid_i  = 1'b1;
        wait_valid(n);
        chk("t2_lat", 32'(n), 32'd1);
        serve("t2a", 1'b1, 32'h200, 5, 32'hA0A0_0001);
        d_valid_i = 1'b0;
        step();
        chk1("t2_gap", mem_rd_valid_o, 1'b0);
        step();
        chk1("t2_regrant", mem_rd_valid_o, 1'b1);
        serve("t2b", 1'b0, 32'h100, 3, 32'hA0A0_0002);
        if_valid_i = 1'b0;

        // Sustained contention alternates d, if, d, if, ...
        addr_m[0]  = 32'h1000;
        addr_m[1]  = 32'h2000;
        if_addr_i  = addr_m[0];
        d_addr_i   = addr_m[1];
        if_valid_i = 1'b1;
        d_valid_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = (i % 2 == 0);
            wait_valid(n);
            chk("t3_lat", 32'(n), 32'd2);
            dat = $urandom;
            serve("t3", w, addr_m[w], 1 + (i % 3), dat);
            addr_m[w] = addr_m[w] + 32'h4;
            if (w) d_addr_i = addr_m[1];
            else   if_addr_i = addr_m[0];
        end
        if_valid_i = 1'b0;
        d_valid_i  = 1'b0;

        // Watchdog: flag rises once TC Busy cycles have elapsed; late data still delivered.
        do_reset();
        if_addr_i  = 32'h40;
        if_valid_i = 1'b1;
        wait_valid(n);
        chk("t4_lat", 32'(n), 32'd1);
        repeat (TC - 1) step();
        chk1("t4_pre_timeout", timeout_o, 1'b0);
        step();
        chk1("t4_timeout", timeout_o, 1'b1);
        repeat (25) step();
        chk1("t4_timeout_hold", timeout_o, 1'b1);
        chk1("t4_still_valid", mem_rd_valid_o, 1'b1);
        serve("t4", 1'b0, 32'h40, 0, 32'h1234_5678);
        if_valid_i = 1'b0;
        chk1("t4_timeout_sticky", timeout_o, 1'b1);
        step();
        chk1("t4_timeout_idle", timeout_o, 1'b1);

        // Spurious ready while Idle.
        do_reset();
        mem_rd_ready_i = 1'b1;
        mem_rd_data_i  = 32'hBAD0_BAD0;
        step();
        mem_rd_ready_i = 1'b0;
        chk1("t5_proto", proto_err_o, 1'b1);
        chk1("t5_ifrdy", if_ready_o, 1'b0);
        chk1("t5_drdy", d_ready_o, 1'b0);
        chk1("t5_rdvalid", mem_rd_valid_o, 1'b0);
        chk("t5_data_ignored", if_data_o, 32'h0);
        step();
        chk1("t5_proto_sticky", proto_err_o, 1'b1);
        if_addr_i  = 32'h80;
        if_valid_i = 1'b1;
        wait_valid(n);
        chk("t5_idle_lat", 32'(n), 32'd1);
        serve("t5", 1'b0, 32'h80, 2, 32'h5555_AAAA);
        if_valid_i = 1'b0;
        chk1("t5_proto_end", proto_err_o, 1'b1);

        // Reset in the middle of Busy, then the first tie goes to data again.
        d_addr_i  = 32'h300;
        d_valid_i = 1'b1;
        wait_valid(n);
        chk("t6_lat", 32'(n), 32'd2);
        repeat (3) step();
        reset_i = 1'b1;
        step();
        reset_i   = 1'b0;
        d_valid_i = 1'b0;
        chk_all_zero("t6_rst");
        if_addr_i  = 32'h500;
        d_addr_i   = 32'h600;
        if_valid_i = 1'b1;
        d_valid_i  = 1'b1;
        wait_valid(n);
        chk("t6_tie_lat", 32'(n), 32'd1);
        serve("t6a", 1'b1, 32'h600, 4, 32'h0600_0600);
        d_valid_i = 1'b0;
        wait_valid(n);
        chk("t6_loser_lat", 32'(n), 32'd2);
        serve("t6b", 1'b0, 32'h500, 1, 32'h0500_0500);
        if_valid_i = 1'b0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        pend       = 2'b00;
        last_m     = 1'b0;
        after_resp = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (pend == 2'b00) begin
                if (after_resp) step();
                repeat ($urandom_range(0, 3)) step();
                pend = 2'($urandom_range(1, 3));
                for (int r = 0; r < 2; r++) if (pend[r]) addr_m[r] = $urandom;
                exp_n = 1;
            end else begin
                exp_n = after_resp ? 2 : 1;
            end
            if_valid_i = pend[0];
            if_addr_i  = addr_m[0];
            d_valid_i  = pend[1];
            d_addr_i   = addr_m[1];
            w      = (pend == 2'b11) ? ~last_m : pend[1];
            last_m = w;
            wait_valid(n);
            chk("rnd_lat", 32'(n), 32'(exp_n));
            lat = int'($urandom_range(0, 6));
            dat = $urandom;
            serve("rnd", w, addr_m[w], lat, dat);
            pend[w]    = 1'b0;
            after_resp = 1'b1;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && ($urandom_range(0, 1) != 0)) begin
                    pend[r]   = 1'b1;
                    addr_m[r] = $urandom;
                end
            end
            if_valid_i = pend[0];
            if_addr_i  = addr_m[0];
            d_valid_i  = pend[1];
            d_addr_i   = addr_m[1];
        end
        drive_idle();
        step();
        chk1("rnd_no_timeout", timeout_o, 1'b0);
        chk1("rnd_no_proto", proto_err_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
